muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide sequencer that owns the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//  Sits beside the EX stage and is started from the decoded ID/EX instruction.
//  Runs a 32-step shift-add (mul) or restoring (div) loop over WIDTH cycles.
//  Raises stall to freeze the pipeline when a later HI/LO access or a new muldiv op arrives while it is busy.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.
// PORTS
//  clk        in   1   clock; all state updates on the rising edge.
//  rst        in   1   synchronous, active-high reset.
//  start      in   1   launch op; qualified by the pipeline not being stalled.
//  op         in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
//  op_x       in   32  rs operand (multiplicand or dividend); sampled with start.
//  op_y       in   32  rt operand (multiplier or divisor); sampled with start.
//  mthi       in   1   write wdata to HI.
//  mtlo       in   1   write wdata to LO.
//  wdata      in   32  rs data for MTHI/MTLO.
//  hilo_read  in   1   the ID instruction is MFHI or MFLO.
//  busy       out  1   operation in progress.
//  done       out  1   one-cycle pulse: HI/LO were just updated by an op.
//  stall      out  1   combinational: busy & (hilo_read | start | mthi | mtlo).
//  hi         out  32  HI register.
//  lo         out  32  LO register.
// BEHAVIOUR
//  Reset: state IDLE, count=0, busy=0, done=0, hi=0, lo=0, hence stall=0.
//   - Reset mid-operation aborts the op; HI/LO clear to 0; no done pulse.
//  States:
//   - IDLE --start--> RUN.
//   - RUN --count==WIDTH-1--> IDLE.
//  Start (edge E0, in IDLE): latch |op_x|, |op_y|, sign flags, count=0.
//   - Signed ops (MULT, DIV) take magnitudes.
//   - Unsigned ops (MULTU, DIVU) use the raw operands.
//  RUN:
//   - One iteration per cycle; count++.
//   - busy=1 for exactly WIDTH cycles after E0.
//  Final edge E32: last iteration plus sign fix; HI/LO written; next cycle busy=0 and done=1 for one cycle.
//   - Results are visible on hi/lo in the cycle after E32.
//  Multiply: 64-bit product; {HI,LO}=product.
//   - Signed: negate the 64-bit product when the operand signs differ.
//  Divide: LO=quotient, HI=remainder.
//   - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
//  Divide by zero (no trap): LO=32'hFFFF_FFFF, HI=op_x (raw), for DIV and DIVU alike.
//  DIV overflow 0x8000_0000 / -1: LO=0x8000_0000, HI=0.
//  MTHI/MTLO in IDLE: HI or LO := wdata at the next edge.
//   - The other register is unchanged.
//   - If start is high the same cycle, start wins and the MT write is dropped.
//  start/mthi/mtlo while busy: ignored.
//   - stall holds the pipeline, so the request re-presents after busy falls.
//  hilo_read while busy: stall=1.
//   - When busy=0, hi/lo are read directly.
//   - No bypass of a same-cycle MTHI/MTLO; the reader sees the old value.
//  done does not depend on start; a start in the done cycle is accepted normally.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles; then HI=0xFFFFFFFE, LO=0x00000001, done pulses once.
//  2. MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  4. hilo_read at busy cycle 5 -> stall=1 until busy falls; start during RUN is ignored and operands are unchanged.
//  5. rst at busy cycle 10 -> next cycle busy=0, hi=lo=0, done stays 0.
//  6. mthi wdata=0x1234 in IDLE -> hi=0x1234 next cycle, lo unchanged; mthi with start -> op runs, hi not overwritten by 0x1234.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// One shift-add (multiply) or restoring (divide) step per cycle, WIDTH steps per operation.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_read,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_e;
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   x_raw_q, x_raw_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               xneg_q, xneg_d;
    logic               yzero_q, yzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, sx, sy;
    logic [WIDTH-1:0]   x_mag, y_mag;
    logic [WIDTH:0]     mul_sum, trial;
    logic [2*WIDTH:0]   mul_step, shifted, div_step, step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot, rem;

    // Operand conditioning at start: signed ops work on magnitudes, signs kept aside.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        sx        = signed_op & op_x[WIDTH-1];
        sy        = signed_op & op_y[WIDTH-1];
        x_mag     = sx ? -op_x : op_x;
        y_mag     = sy ? -op_y : op_y;
    end

    // acc holds {upper(WIDTH+1), lower(WIDTH)}; lower starts as x for both algorithms.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, y_q};
        mul_step = acc_q[0] ? ({mul_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);
        shifted  = acc_q << 1;
        trial    = shifted[2*WIDTH:WIDTH] - {1'b0, y_q};
        div_step = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};
        step     = div_q ? div_step : mul_step;
        prod     = step[2*WIDTH-1:0];
        prod_fix = neg_q ? -prod : prod;
        quot     = step[WIDTH-1:0];
        rem      = step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        y_d     = y_q;
        x_raw_d = x_raw_q;
        div_d   = div_q;
        neg_d   = neg_q;
        xneg_d  = xneg_q;
        yzero_d = yzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                    acc_d   = {{(WIDTH+1){1'b0}}, x_mag};
                    y_d     = y_mag;
                    x_raw_d = op_x;
                    div_d   = op[1];
                    neg_d   = sx ^ sy;
                    xneg_d  = sx;
                    yzero_d = (op_y == '0);
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH-1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (yzero_q) begin
                        lo_d = '1;
                        hi_d = x_raw_q;
                    end else begin
                        lo_d = neg_q  ? -quot : quot;
                        hi_d = xneg_q ? -rem  : rem;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            x_raw_q <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            xneg_q  <= 1'b0;
            yzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            x_raw_q <= x_raw_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            xneg_q  <= xneg_d;
            yzero_q <= yzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign stall = busy & (hilo_read | start | mthi | mtlo);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
